// File: rtl/alu_bcd_converter_pkg.sv
// Shared types and constants for the ALU-result to BCD converter.
package alu_bcd_converter_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_DIGITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True when DIGITS decimal digits can represent every WIDTH-bit magnitude.
  function automatic bit bcd_digits_ok(input int unsigned digits, input int unsigned width);
    logic [255:0] p;
    p = 256'(1);
    for (int unsigned i = 0; i < digits; i++) p = p * 256'(10);
    return p > (256'(1) << width);
  endfunction

endpackage

// File: rtl/alu_bcd_converter_if.sv
// Valid/ready handshake bundle between the ALU, the converter and the display stage.
interface alu_bcd_converter_if #(
  parameter int unsigned WIDTH  = alu_bcd_converter_pkg::DEF_WIDTH,
  parameter int unsigned DIGITS = alu_bcd_converter_pkg::DEF_DIGITS
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  sign_out;
  logic                  busy;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, sign_out, busy
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, sign_out, busy
  );
endinterface

// File: rtl/alu_bcd_converter_bcd_add3.sv
// Single BCD digit correction applied before each double-dabble shift.
module alu_bcd_converter_bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] dig_c
);
  assign dig_c = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/alu_bcd_converter.sv
// Iterative double-dabble converter: one magnitude bit per cycle, signed-magnitude BCD result.
module alu_bcd_converter
  import alu_bcd_converter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DIGITS = DEF_DIGITS,
  parameter bit          SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_bcd_converter_if.slave bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  if (!bcd_digits_ok(DIGITS, WIDTH)) begin : g_digits_check
    $error("alu_bcd_converter: DIGITS too small for WIDTH");
  end

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mag;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   acc_adj_c;
  logic [BCD_W-1:0]   acc_shift_c;
  logic               sign_q;
  logic               accept_c;
  logic               last_c;
  logic               in_sign_c;
  logic [WIDTH-1:0]   in_mag_c;

  // Two's complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
  assign in_sign_c = SIGNED & bus.bin_in[WIDTH-1];
  assign in_mag_c  = in_sign_c ? WIDTH'(~bus.bin_in + WIDTH'(1)) : bus.bin_in;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
    alu_bcd_converter_bcd_add3 u_add3 (
      .d     (acc[4*g +: 4]),
      .dig_c (acc_adj_c[4*g +: 4])
    );
  end

  assign acc_shift_c = {acc_adj_c[BCD_W-2:0], mag[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept_c = 1'b1;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == CNT_W'(1)) begin
          last_c   = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Handshake flags registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.in_ready  <= 1'b1;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.in_ready  <= (state_nx == ST_IDLE);
      bus.busy      <= (state_nx == ST_SHIFT);
      bus.out_valid <= (state_nx == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      mag          <= '0;
      acc          <= '0;
      sign_q       <= 1'b0;
      bus.bcd_out  <= '0;
      bus.sign_out <= 1'b0;
    end else if (accept_c) begin
      cnt    <= CNT_W'(WIDTH);
      mag    <= in_mag_c;
      acc    <= '0;
      sign_q <= in_sign_c;
    end else if (state == ST_SHIFT) begin
      cnt <= cnt - CNT_W'(1);
      mag <= {mag[WIDTH-2:0], 1'b0};
      acc <= acc_shift_c;
      if (last_c) begin
        bus.bcd_out  <= acc_shift_c;
        bus.sign_out <= sign_q;
      end
    end
  end

endmodule
